// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
//   WORD_W  : data word width
//   CNT_W   : wait-state counter width (supports WAIT_CYCLES 0..15)
//   state_t : responder FSM states
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a requester (master) and the responder (slave).
//   req_valid/req_ready : request handshake
//   req_we/req_addr/req_wdata : request payload (byte address)
//   resp_valid : one-cycle response pulse
//   resp_rdata/resp_err : response payload
interface dmem_responder_if #(
  parameter int unsigned ADDR_W = 16
);
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x WORD_W storage: synchronous write, combinational read, no reset.
//   clk       : write clock
//   i_we      : write enable
//   i_idx     : word index (shared by read and write)
//   i_wdata   : write data
//   o_rdata_c : combinational read data at i_idx
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata_c
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Storage write
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts
// WAIT_CYCLES wait states, then returns a registered one-cycle response.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : dmem_responder_if slave (request handshake + response)
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned accesses skip the
// array and respond with resp_err=1; otherwise addr[1:0] is ignored.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WORD_IDX_W = ADDR_W - 2;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_we;
  logic [WORD_IDX_W-1:0] r_word;
  logic [WORD_W-1:0]     r_wdata;

  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [WORD_W-1:0]     r_resp_rdata;
  logic                  r_resp_err;

  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_misalign;
  logic                  w_arr_we;
  logic [WORD_W-1:0]     w_arr_rdata;
  logic                  w_ready_nxt;
  logic                  w_resp_valid_nxt;
  logic [WORD_W-1:0]     w_resp_rdata_nxt;
  logic                  w_resp_err_nxt;

  assign w_accept = bus.req_valid & r_req_ready;

  // Word indices beyond DEPTH neither read nor write the array
  generate
    if (WORD_IDX_W > IDX_W) begin : g_range
      assign w_in_range = ~|r_word[WORD_IDX_W-1:IDX_W];
    end else begin : g_no_range
      assign w_in_range = 1'b1;
    end
  endgenerate

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_misalign;

  // Byte offset of the captured request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_accept) begin
      r_misalign <= |bus.req_addr[1:0];
    end
  end

  assign w_misalign = r_misalign;
`else
  logic w_unused_lsb;

  assign w_unused_lsb = ^bus.req_addr[1:0];
  assign w_misalign   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode; the response registers load during RESP so the pulse
  // lands one cycle later, on the same edge that commits a store
  always_comb begin
    w_arr_we         = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_resp_rdata_nxt = '0;
    w_resp_err_nxt   = 1'b0;
    w_ready_nxt      = (w_state_nxt == IDLE);
    if (r_state == RESP) begin
      w_resp_valid_nxt = 1'b1;
      w_resp_err_nxt   = w_misalign;
      w_arr_we         = r_we & w_in_range & ~w_misalign;
      if (!r_we && w_in_range && !w_misalign) begin
        w_resp_rdata_nxt = w_arr_rdata;
      end
    end
  end

  // Capture, wait counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_word       <= '0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_req_ready  <= w_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_word  <= bus.req_addr[ADDR_W-1:2];
        r_wdata <= bus.req_wdata;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk       (clk),
    .i_we      (w_arr_we),
    .i_idx     (r_word[IDX_W-1:0]),
    .i_wdata   (r_wdata),
    .o_rdata_c (w_arr_rdata)
  );

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with two wait states,
// one with zero wait states, both compared against a word-array model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned W2     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(ADDR_W)) bus2 ();
  dmem_responder_if #(.ADDR_W(ADDR_W)) bus0 ();

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W2), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .ADDR_W(ADDR_W)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem2 [DEPTH];
  logic [31:0] ref_mem0 [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural memory: word-addressed array, out-of-range and trapped
  // misaligned accesses touch nothing
  task automatic ref_access(input bit sel0, input logic we, input logic [15:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int idx;
    bit mis;
    idx = int'(addr) / 4;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (addr % 4) != 0;
`else
    mis = 1'b0;
`endif
    err = mis;
    rd  = '0;
    if (!mis && idx < int'(DEPTH)) begin
      if (we) begin
        if (sel0) ref_mem0[idx] = wd;
        else      ref_mem2[idx] = wd;
      end else begin
        rd = sel0 ? ref_mem0[idx] : ref_mem2[idx];
      end
    end
  endtask

  // One full transaction on the two-wait-state instance
  task automatic txn2(input logic we, input logic [15:0] addr, input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          n;
    ref_access(1'b0, we, addr, wd, exp_rd, exp_err);
    bus2.req_valid = 1'b1;
    bus2.req_we    = we;
    bus2.req_addr  = addr;
    bus2.req_wdata = wd;
    chk("ready_idle", 32'(bus2.req_ready), 32'd1);
    tick();
    // live inputs change after acceptance; only captured values may matter
    bus2.req_valid = 1'b0;
    bus2.req_we    = 1'($urandom);
    bus2.req_addr  = 16'($urandom);
    bus2.req_wdata = $urandom;
    n = 0;
    while (bus2.resp_valid !== 1'b1 && n < 40) begin
      chk("ready_busy", 32'(bus2.req_ready), 32'd0);
      chk("rdata_quiet", bus2.resp_rdata, 32'd0);
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(W2 + 1));
    chk("rdata", bus2.resp_rdata, exp_rd);
    chk("err", 32'(bus2.resp_err), 32'(exp_err));
    chk("ready_at_resp", 32'(bus2.req_ready), 32'd1);
    tick();
    chk("valid_pulse", 32'(bus2.resp_valid), 32'd0);
    chk("rdata_idle", bus2.resp_rdata, 32'd0);
  endtask

  logic [15:0] s_addr [8];
  logic        s_we   [8];
  logic [31:0] s_data [8];

  initial begin
    int          q_cyc [$];
    logic [31:0] q_rd  [$];
    logic [31:0] rd;
    logic        er;
    int          si;
    int          last_acc;
    int          acc_cnt;
    bit          acc;
    int          n;

    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;

    // Reset held, then idle
    for (int i = 0; i < 6; i++) begin
      if (i == 3) rst = 1'b0;
      tick();
      chk("rst_ready2", 32'(bus2.req_ready), 32'd1);
      chk("rst_valid2", 32'(bus2.resp_valid), 32'd0);
      chk("rst_rdata2", bus2.resp_rdata, 32'd0);
      chk("rst_err2", 32'(bus2.resp_err), 32'd0);
      chk("rst_ready0", 32'(bus0.req_ready), 32'd1);
      chk("rst_valid0", 32'(bus0.resp_valid), 32'd0);
    end

    // Fill every word so later loads have known contents
    for (int i = 0; i < int'(DEPTH); i++) begin
      txn2(1'b1, 16'(i * 4), $urandom);
    end

    // Store then load the same word
    txn2(1'b1, 16'h0010, 32'hDEADBEEF);
    txn2(1'b0, 16'h0010, 32'h0);

    // Out-of-range index: load returns 0, store leaves word 0 untouched
    txn2(1'b1, 16'h0000, 32'hA5A5_0001);
    txn2(1'b0, 16'h0400, 32'h0);
    txn2(1'b1, 16'h0400, 32'h5A5A_0002);
    txn2(1'b0, 16'h0000, 32'h0);

    // Misaligned store, then read back the enclosing word
    txn2(1'b1, 16'h0013, 32'h1234_5678);
    txn2(1'b0, 16'h0010, 32'h0);
    txn2(1'b0, 16'h0013, 32'h0);

    // Reset during WAIT of a store aborts it
    txn2(1'b1, 16'h0020, 32'h1111_1111);
    bus2.req_valid = 1'b1; bus2.req_we = 1'b1;
    bus2.req_addr = 16'h0020; bus2.req_wdata = 32'h2222_2222;
    tick();
    bus2.req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(bus2.resp_valid), 32'd0);
    chk("abort_ready", 32'(bus2.req_ready), 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_resp", 32'(bus2.resp_valid), 32'd0);
    end
    txn2(1'b0, 16'h0020, 32'h0);

    // Reset during the response pulse drops it at once
    bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_addr = 16'h0024;
    tick();
    bus2.req_valid = 1'b0;
    n = 0;
    while (bus2.resp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("rstresp_seen", 32'(n), 32'(W2 + 1));
    rst = 1'b1;
    #1;
    chk("rstresp_valid", 32'(bus2.resp_valid), 32'd0);
    chk("rstresp_rdata", bus2.resp_rdata, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Randomized traffic, including out-of-range and misaligned addresses
    for (int i = 0; i < 80; i++) begin
      txn2(1'($urandom), 16'($urandom_range(0, 16'h047F)), $urandom);
    end

    // Zero wait states, req_valid held high across a 4-store + 4-load stream
    for (int i = 0; i < 4; i++) begin
      s_addr[i] = 16'(16'h0040 + 4 * i); s_we[i] = 1'b1; s_data[i] = $urandom;
    end
    s_addr[4] = 16'h0044; s_addr[5] = 16'h0040; s_addr[6] = 16'h004C; s_addr[7] = 16'h0048;
    for (int i = 4; i < 8; i++) begin
      s_we[i] = 1'b0; s_data[i] = $urandom;
    end
    si = 0;
    last_acc = -100;
    acc_cnt = 0;
    bus0.req_valid = 1'b1; bus0.req_we = s_we[0];
    bus0.req_addr = s_addr[0]; bus0.req_wdata = s_data[0];
    for (int c = 0; c < 40; c++) begin
      chk("b2b_ready", 32'(bus0.req_ready), 32'(c != last_acc + 1));
      if (q_cyc.size() > 0 && q_cyc[0] == c) begin
        chk("b2b_valid", 32'(bus0.resp_valid), 32'd1);
        chk("b2b_rdata", bus0.resp_rdata, q_rd[0]);
        void'(q_cyc.pop_front());
        void'(q_rd.pop_front());
      end else begin
        chk("b2b_idle", 32'(bus0.resp_valid), 32'd0);
        chk("b2b_idle_rdata", bus0.resp_rdata, 32'd0);
      end
      acc = (bus0.req_valid === 1'b1) && (bus0.req_ready === 1'b1);
      if (acc) begin
        ref_access(1'b1, s_we[si], s_addr[si], s_data[si], rd, er);
        q_cyc.push_back(c + 2);
        q_rd.push_back(rd);
        if (last_acc >= 0) chk("b2b_spacing", 32'(c - last_acc), 32'd2);
        last_acc = c;
        acc_cnt++;
      end
      tick();
      if (acc) begin
        si++;
        if (si < 8) begin
          bus0.req_we = s_we[si]; bus0.req_addr = s_addr[si]; bus0.req_wdata = s_data[si];
        end else begin
          bus0.req_valid = 1'b0;
        end
      end
    end
    chk("b2b_accepts", 32'(acc_cnt), 32'd8);
    chk("b2b_drained", 32'(q_cyc.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the datapath's data-memory port. It accepts one load/store request at a time over a valid/ready handshake, inserts a configurable number of wait states, then returns a one-cycle response with read data. It replaces the zero-wait, combinational data memory so the core and a future multi-cycle controller can be exercised against realistic memory latency.

## Interface
- `DEPTH`, 256: number of 32-bit words stored. Power of two.
- `WAIT_CYCLES`, 2: wait states between acceptance and response. Legal range 0..15.
- `ADDR_W`, 16: width of the byte address.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned-access flag; constant 0 unless the macro is enabled.

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`&`req_ready`, capture `we`, `addr` and `wdata`. Go to WAIT if `WAIT_CYCLES`>0, else to RESP. On entry to WAIT the counter loads `WAIT_CYCLES`-1.
  - WAIT: decrement the counter each cycle. At 0, go to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle. Return to IDLE unconditionally. There is no response backpressure.
- Word index = captured `addr[ADDR_W-1:2]`. Addresses with index ≥ `DEPTH`:
  - loads return 0;
  - stores are dropped;
  - no error is signalled.
- A store commits to the array on the clock edge that ends RESP. `resp_rdata`=0 for stores.
- A load reads the array during RESP. `resp_rdata` is registered and valid only while `resp_valid`=1; otherwise it holds 0.
- Read-after-write: a load accepted after a store to the same word returns the stored value.
- Request inputs are ignored outside IDLE. The captured values are used, not the live inputs.
- Array contents are not reset.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter 0.
- Request accepted at edge k → `resp_valid` high in the cycle after edge k+`WAIT_CYCLES`+1.
  - `WAIT_CYCLES`=0 → response in the cycle right after acceptance.
- `req_ready` returns high in the cycle after RESP.
- Maximum throughput is one transaction per `WAIT_CYCLES`+2 cycles.
- Reset asserted mid-transaction (WAIT or RESP):
  - the transaction is discarded;
  - no store commits;
  - `resp_valid` drops immediately.
- `req_valid` held high across a response: the next request is accepted in the IDLE cycle that follows RESP.

## Configuration
- Macro: `DMEM_MISALIGN_TRAP_EN`.
- Defined: a captured `addr[1:0]`≠0 means no array access (stores dropped). The response has the same latency, with `resp_err`=1 and `resp_rdata`=0.
- Undefined: `addr[1:0]` is ignored and `resp_err` is tied to 0.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (IDLE, WAIT, RESP);
  - `WORD_W`=32;
  - the wait-counter width (4).
- Sub-module `dmem_array`: `DEPTH`×32 storage with synchronous write and combinational read. It is instantiated once.
- The FSM, capture registers and counter live in `dmem_responder`.

## Test plan
- Reset then idle: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0 throughout.
- `WAIT_CYCLES`=2, store 0xDEADBEEF to addr 0x0010, then load 0x0010:
  - each `resp_valid` arrives 3 cycles after acceptance;
  - the load returns 0xDEADBEEF.
- `WAIT_CYCLES`=0 back-to-back, with `req_valid` held high for 4 loads:
  - one response every 2 cycles;
  - `req_ready` low during each RESP.
- Load from index ≥ `DEPTH` (addr 0x0400 with `DEPTH`=256) → `rdata`=0, `err`=0. A store to that address leaves the array unchanged.
- Assert `rst` during WAIT of a store to 0x0020, then load 0x0020 → the earlier value is returned and no `resp_valid` appears for the aborted store.
- With `DMEM_MISALIGN_TRAP_EN`: store to 0x0013 → `resp_err`=1 and memory unchanged. Without the macro, the same store writes word 4 and `resp_err`=0.
